// File: rtl/dlatch_write_sequencer_pkg.sv
// Shared types, default timing constants and elaboration helpers for the
// D latch write sequencer.
package dlatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_OPEN  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int DEF_WIDTH     = 1;
    localparam int DEF_SETUP_CYC = 2;
    localparam int DEF_OPEN_CYC  = 4;
    localparam int DEF_HOLD_CYC  = 2;
    localparam int DEF_CNT_W     = 8;

    // Bits needed to index 'value' distinct states (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dlatch_write_sequencer_if.sv
// Handshake and latch-bank signals between a word producer and the sequencer.
interface dlatch_write_sequencer_if
    import dlatch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);

    logic [WIDTH-1:0] IN_DATA;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] D_OUT;
    logic             EN_OUT;
    logic             BUSY;
    logic             DONE;
    logic [CNT_W-1:0] WR_COUNT;

    modport master (
        output IN_DATA, IN_VALID,
        input  IN_READY, D_OUT, EN_OUT, BUSY, DONE, WR_COUNT
    );

    modport slave (
        input  IN_DATA, IN_VALID,
        output IN_READY, D_OUT, EN_OUT, BUSY, DONE, WR_COUNT
    );

endinterface

// File: rtl/dlatch_write_sequencer_phase_counter.sv
// Loadable down-counter timing each phase of a latch write; it parks at zero.
module dlatch_phase_counter #(
    parameter int CW = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          LOAD,
    input  logic [CW-1:0] LOAD_VAL,
    output logic          ZERO
);

    logic [CW-1:0] cnt_q;

    // Load a new phase length, otherwise count down until zero and stay there.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (LOAD) begin
            cnt_q <= LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign ZERO = (cnt_q == '0);

endmodule

// File: rtl/dlatch_write_sequencer.sv
// Drives a D latch bank: presents D for a setup window, pulses EN for an
// open window, then holds D for a hold window before accepting the next word.
module dlatch_write_sequencer
    import dlatch_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int OPEN_CYC  = DEF_OPEN_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic CLK,
    input  logic RST,
    dlatch_write_sequencer_if.slave bus
);

    // A phase of length N only ever loads N-1, so clog2(N) bits suffice;
    // keep at least one bit when every phase is a single cycle.
    localparam int MAX_CYC = max3(SETUP_CYC, OPEN_CYC, HOLD_CYC);
    localparam int CW      = (clog2(MAX_CYC) < 1) ? 1 : clog2(MAX_CYC);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] OPEN_LD  = CW'(OPEN_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

    generate
        if (SETUP_CYC < 1 || OPEN_CYC < 1 || HOLD_CYC < 1 || WIDTH < 1 || CNT_W < 1) begin : g_badParams
            $error("dlatch_write_sequencer: all timing and width parameters must be >= 1");
        end
    endgenerate

    state_t           state_q;
    logic [WIDTH-1:0] dOut_q;
    logic             enOut_q;
    logic             done_q;
    logic [CNT_W-1:0] wrCount_q;
    logic [CNT_W-1:0] wrCount_d;

    logic             inReady;
    logic             accept;
    logic             cntZero;
    logic             loadEn;
    logic [CW-1:0]    loadVal;

    assign inReady   = (state_q == ST_IDLE) && !RST;
    assign accept    = bus.IN_VALID && inReady;
    assign wrCount_d = wrCount_q + CNT_W'(1);

    // Pick the length of the phase being entered on each state transition.
    always_comb begin
        loadEn  = 1'b0;
        loadVal = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    loadEn  = 1'b1;
                    loadVal = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cntZero) begin
                    loadEn  = 1'b1;
                    loadVal = OPEN_LD;
                end
            end
            ST_OPEN: begin
                if (cntZero) begin
                    loadEn  = 1'b1;
                    loadVal = HOLD_LD;
                end
            end
            default: begin
                loadEn  = 1'b0;
                loadVal = '0;
            end
        endcase
    end

    dlatch_phase_counter #(
        .CW (CW)
    ) u_phaseCounter (
        .CLK      (CLK),
        .RST      (RST),
        .LOAD     (loadEn),
        .LOAD_VAL (loadVal),
        .ZERO     (cntZero)
    );

    // Sequencer FSM; D is captured only on accept so it is frozen while busy.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            dOut_q    <= '0;
            enOut_q   <= 1'b0;
            done_q    <= 1'b0;
            wrCount_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    enOut_q <= 1'b0;
                    if (accept) begin
                        dOut_q  <= bus.IN_DATA;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cntZero) begin
                        enOut_q <= 1'b1;
                        state_q <= ST_OPEN;
                    end
                end
                ST_OPEN: begin
                    if (cntZero) begin
                        enOut_q <= 1'b0;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cntZero) begin
                        state_q   <= ST_IDLE;
                        done_q    <= 1'b1;
                        wrCount_q <= wrCount_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    enOut_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.IN_READY = inReady;
    assign bus.D_OUT    = dOut_q;
    assign bus.EN_OUT   = enOut_q;
    assign bus.BUSY     = (state_q != ST_IDLE);
    assign bus.DONE     = done_q;
    assign bus.WR_COUNT = wrCount_q;

endmodule
